rib_uart: RTL and testbench



---
 rtl/rib_uart_pkg.sv | 41 ++++
 rtl/rib_uart_fifo.sv | 58 +++++
 rtl/rib_uart.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rib_uart.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_uart_pkg.sv
// rib_uart_pkg: shared constants for the RIB UART.
//   - register word offsets (addr_i[3:2])
//   - CTRL / STATUS bit positions
//   - 2-bit FSM state encoding shared by the TX and RX engines
//   - minimum bit period and the helper that clamps the baud divider
package rib_uart_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_TXE_IRQ = 2;
  localparam int CTRL_RXV_IRQ = 3;
  localparam int CTRL_LOOP    = 4;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam logic [15:0] MIN_PERIOD = 16'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Bit period in clock cycles; very small dividers are clamped so the
  // RX mid-bit sample point stays meaningful.
  function automatic logic [15:0] bit_period(input logic [15:0] div);
    return (div < MIN_PERIOD) ? MIN_PERIOD : div;
  endfunction

endpackage

// File: rtl/rib_uart_fifo.sv
// rib_uart_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write strobe / data; a push while full is dropped
//   pop           read strobe; dout always shows the oldest entry
//   full, empty   occupancy flags
// DEPTH must be a power of two, minimum 2.
module rib_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rptr];

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rib_uart.sv
// rib_uart: memory-mapped UART slave on the RIB data bus.
//   clk, rst       core clock, synchronous active-high reset
//   req_i, we_i    bus request / write enable
//   addr_i[3:2]    register select (CTRL, STATUS, BAUD, DATA)
//   data_i, data_o write data / combinational read data
//   tx_o, rx_i     serial line (rx_i is asynchronous to clk)
//   irq_o          registered level interrupt
// Optional build macro UART_LOOPBACK_EN adds CTRL[4] (internal TX->RX loop).
module rib_uart
  import rib_uart_pkg::*;
#(
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_DIV_RST  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        irq_o
);

  logic [3:0]  r_ctrl;
  logic [15:0] r_baud;
  logic        r_irq;

  // Bus decode
  logic w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_data, w_rd_data;
  assign w_wr_ctrl   = req_i &  we_i & (addr_i[3:2] == ADDR_CTRL);
  assign w_wr_status = req_i &  we_i & (addr_i[3:2] == ADDR_STATUS);
  assign w_wr_baud   = req_i &  we_i & (addr_i[3:2] == ADDR_BAUD);
  assign w_wr_data   = req_i &  we_i & (addr_i[3:2] == ADDR_DATA);
  assign w_rd_data   = req_i & ~we_i & (addr_i[3:2] == ADDR_DATA);

  logic w_unused;
  assign w_unused = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  logic w_loop;
`ifdef UART_LOOPBACK_EN
  logic r_loop;
  always_ff @(posedge clk) begin
    if (rst)            r_loop <= 1'b0;
    else if (w_wr_ctrl) r_loop <= data_i[CTRL_LOOP];
  end
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_baud <= BAUD_DIV_RST;
    end else begin
      if (w_wr_ctrl) r_ctrl <= data_i[3:0];
      if (w_wr_baud) r_baud <= data_i[15:0];
    end
  end

  logic [15:0] w_period;
  assign w_period = bit_period(r_baud);

  // TX FIFO
  logic [7:0] w_fifo_dout;
  logic       w_full, w_empty, w_tx_pop;

  rib_uart_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_wr_data),
    .din   (data_i[7:0]),
    .pop   (w_tx_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // TX engine
  uart_state_t r_tx_state;
  logic [15:0] r_tx_per, r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx_out;
  logic        w_tx_last, w_tx_busy;

  assign w_tx_busy = (r_tx_state != S_IDLE);
  assign w_tx_pop  = (r_tx_state == S_IDLE) & r_ctrl[CTRL_TX_EN] & ~w_empty;
  assign w_tx_last = (r_tx_cnt == r_tx_per - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_per   <= MIN_PERIOD;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          r_tx_out <= 1'b1;
          if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_shift <= w_fifo_dout;
            r_tx_per   <= w_period;   // frame keeps this period even if BAUD changes
            r_tx_cnt   <= '0;
            r_tx_out   <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_last) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_DATA;
            r_tx_out   <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_tx_last) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx_out   <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_out   <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        default: begin // S_STOP
          if (w_tx_last) begin
            r_tx_cnt   <= '0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign tx_o = r_tx_out | w_loop;

  // RX engine
  logic        w_rx_src, w_rx_fall;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  uart_state_t r_rx_state;
  logic [15:0] r_rx_per, r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift, r_rx_byte;
  logic        r_rx_valid, r_rx_ovr, r_frame_err;
  logic        w_rx_last;

  assign w_rx_src  = w_loop ? r_tx_out : rx_i;
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_last = (r_rx_cnt == r_rx_per - 16'd1);

  // Status clears from the bus come first so that same-edge sets from the
  // receiver (written later in this block) take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= S_IDLE;
      r_rx_per    <= MIN_PERIOD;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1   <= w_rx_src;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (w_rd_data) r_rx_valid <= 1'b0;
      if (w_wr_status & data_i[ST_RX_OVR])    r_rx_ovr    <= 1'b0;
      if (w_wr_status & data_i[ST_FRAME_ERR]) r_frame_err <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (r_ctrl[CTRL_RX_EN] & w_rx_fall) begin
            r_rx_state <= S_START;
            r_rx_per   <= w_period;
            r_rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_rx_cnt == (r_rx_per >> 1)) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;  // high at mid-start = glitch
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_rx_last) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: begin // S_STOP
          if (w_rx_last) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
            if (r_rx_s2) begin
              // A same-edge DATA read frees the holding register.
              if (~r_rx_valid | w_rd_data) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_rx_ovr <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Interrupt
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (r_ctrl[CTRL_TXE_IRQ] & w_empty & ~w_tx_busy) |
                      (r_ctrl[CTRL_RXV_IRQ] & r_rx_valid);
  end
  assign irq_o = r_irq;

  // Register read mux
  always_comb begin
    data_o = '0;
    case (addr_i[3:2])
      ADDR_CTRL:   data_o[4:0]  = {w_loop, r_ctrl};
      ADDR_STATUS: data_o[5:0]  = {r_frame_err, w_tx_busy, r_rx_ovr,
                                   r_rx_valid, w_empty, w_full};
      ADDR_BAUD:   data_o[15:0] = r_baud;
      default:     data_o[7:0]  = r_rx_byte;
    endcase
  end

endmodule

// File: tb/tb_rib_uart.sv
// tb_rib_uart: self-checking bench for rib_uart. Expected line waveforms and
// register values come from the UART frame rules (start 0, 8 data LSB-first,
// stop 1, P = max(div,4)) and a byte queue for the TX FIFO.
module tb_rib_uart;

  logic        clk = 1'b0;
  logic        rst, req_i, we_i, rx_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        tx_o, irq_o;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  last_rx = 8'h00;

  always #5 clk = ~clk;

  rib_uart #(.TX_FIFO_DEPTH(8), .BAUD_DIV_RST(16'd434)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .rx_i(rx_i), .irq_o(irq_o)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(negedge clk); req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); req_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 d = data_o;
    @(negedge clk); req_i = 1'b0;
  endtask

  // Drive one serial frame on rx_i, each bit held p cycles.
  task automatic send_rx(input logic [7:0] d, input bit stop, input int p);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk); rx_i = bits[b];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk); rx_i = 1'b1;
  endtask

  // Wait for a start bit, then compare every cycle of the frame to the
  // expected bit; optionally watch tx_busy through STATUS.
  task automatic tx_check_frame(input logic [7:0] d, input int p, input bit chk_busy);
    logic [9:0] bits;
    bit found, bad;
    logic obs;
    bits  = {1'b1, d, 1'b0};
    found = 0;
    @(negedge clk);
    if (chk_busy) begin req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4; end
    for (int k = 0; k < 40; k++) begin
      if (tx_o === 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL tx_start byte=%h: no start bit within 40 cycles", d);
      req_i = 1'b0; return;
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0; obs = bits[b];
      for (int s = 0; s < p; s++) begin
        if (tx_o !== bits[b]) begin bad = 1; obs = tx_o; end
        if (chk_busy && b == 9 && s == p - 1) begin
          n_cmp++;
          if (data_o[4] !== 1'b1) begin n_err++; $display("FAIL tx_busy_end byte=%h got %b exp 1", d, data_o[4]); end
        end
        @(negedge clk);
      end
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL tx_bit byte=%h p=%0d bit=%0d got %b exp %b", d, p, b, obs, bits[b]); end
    end
    n_cmp++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL tx_idle byte=%h got %b exp 1", d, tx_o); end
    if (chk_busy) begin
      n_cmp++;
      if (data_o[4] !== 1'b0) begin n_err++; $display("FAIL tx_busy_drop byte=%h got %b exp 0 at 10P", d, data_o[4]); end
      req_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_read(32'h0, r); n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL rst_ctrl got %h exp 00000000", r); end
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h2) begin n_err++; $display("FAIL rst_status got %h exp 00000002", r); end
    bus_read(32'h8, r); n_cmp++;
    if (r !== 32'd434) begin n_err++; $display("FAIL rst_baud got %0d exp 434", r); end
    bus_read(32'hC, r); n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL rst_data got %h exp 00000000", r); end
    n_cmp++;
    if (tx_o !== 1'b1 || irq_o !== 1'b0) begin n_err++; $display("FAIL rst_pins got tx=%b irq=%b exp tx=1 irq=0", tx_o, irq_o); end
  endtask

  task automatic test_tx();
    logic [7:0] d;
    int bd, p;
    bus_write(32'h8, 32'd4); bus_write(32'h0, 32'h1);
    bus_write(32'hC, 32'hA5); tx_check_frame(8'hA5, 4, 1);
    for (int i = 0; i < 4; i++) begin
      bd = (i == 0) ? 0 : $urandom_range(1, 9);
      p  = (bd < 4) ? 4 : bd;
      d  = 8'($urandom);
      bus_write(32'h8, 32'(bd)); bus_write(32'hC, {24'h0, d});
      tx_check_frame(d, p, 1);
    end
    bus_write(32'h0, 32'h0);
  endtask

  // BAUD changed mid-frame: current frame keeps P=4, next frame uses 6.
  task automatic test_baud_latch();
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    bus_write(32'h8, 32'd4);
    bus_write(32'hC, {24'h0, a}); bus_write(32'hC, {24'h0, b});
    bus_write(32'h0, 32'h1);
    fork
      begin tx_check_frame(a, 4, 0); tx_check_frame(b, 6, 0); end
      begin repeat (6) @(negedge clk); bus_write(32'h8, 32'd6); end
    join
    bus_write(32'h0, 32'h0);
  endtask

  task automatic test_fifo_full();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [31:0] r;
    bus_write(32'h8, 32'd4);
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      bus_write(32'hC, {24'h0, d});
      if (q.size() < 8) q.push_back(d);
      if (i == 0 || i >= 7) begin
        bus_read(32'h4, r); n_cmp++;
        if (r !== ((q.size() == 8) ? 32'h1 : 32'h0)) begin
          n_err++; $display("FAIL fifo_status after %0d pushes got %h exp %h", i + 1, r, (q.size() == 8) ? 32'h1 : 32'h0);
        end
      end
    end
    bus_write(32'h0, 32'h1);
    n_cmp++;
    if (q.size() !== 8) begin n_err++; $display("FAIL fifo_model_size got %0d exp 8", q.size()); end
    while (q.size() > 0) tx_check_frame(q.pop_front(), 4, 1);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL fifo_extra_frame got tx=%b exp 1", tx_o); end
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h2) begin n_err++; $display("FAIL fifo_drained got %h exp 00000002", r); end
    bus_write(32'h0, 32'h0);
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic [31:0] r;
    int pl[4] = '{4, 5, 8, 11};
    int p;
    bus_write(32'h0, 32'h2);
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h3C : 8'($urandom);
      p = (i == 0) ? 8 : pl[$urandom_range(0, 3)];
      bus_write(32'h8, 32'(p));
      send_rx(d, 1, p); repeat (3) @(negedge clk);
      bus_read(32'h4, r); n_cmp++;
      if (r !== 32'h6) begin n_err++; $display("FAIL rx_valid p=%0d got %h exp 00000006", p, r); end
      bus_read(32'hC, r); n_cmp++;
      if (r !== {24'h0, d}) begin n_err++; $display("FAIL rx_data p=%0d got %h exp %h", p, r, d); end
      last_rx = d;
      bus_read(32'h4, r); n_cmp++;
      if (r !== 32'h2) begin n_err++; $display("FAIL rx_valid_clr got %h exp 00000002", r); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d1, d2;
    logic [31:0] r;
    d1 = 8'($urandom); d2 = ~d1;
    bus_write(32'h8, 32'd8);
    send_rx(d1, 1, 8); send_rx(d2, 1, 8); repeat (3) @(negedge clk);
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'hE) begin n_err++; $display("FAIL ovr_status got %h exp 0000000e", r); end
    bus_write(32'h4, 32'h8);
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h6) begin n_err++; $display("FAIL ovr_w1c got %h exp 00000006", r); end
    bus_read(32'hC, r); n_cmp++;
    if (r !== {24'h0, d1}) begin n_err++; $display("FAIL ovr_keep_first got %h exp %h", r, d1); end
    last_rx = d1;
  endtask

  task automatic test_frame_err();
    logic [31:0] r;
    send_rx(~last_rx, 0, 8); repeat (3) @(negedge clk);
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h22) begin n_err++; $display("FAIL ferr_status got %h exp 00000022", r); end
    bus_read(32'hC, r); n_cmp++;
    if (r !== {24'h0, last_rx}) begin n_err++; $display("FAIL ferr_discard got %h exp %h", r, last_rx); end
    bus_write(32'h4, 32'h20);
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h2) begin n_err++; $display("FAIL ferr_w1c got %h exp 00000002", r); end
  endtask

  task automatic test_glitch();
    logic [31:0] r;
    @(negedge clk); rx_i = 1'b0;
    repeat (2) @(negedge clk); rx_i = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h2) begin n_err++; $display("FAIL glitch_status got %h exp 00000002", r); end
    bus_read(32'hC, r); n_cmp++;
    if (r !== {24'h0, last_rx}) begin n_err++; $display("FAIL glitch_data got %h exp %h", r, last_rx); end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    logic [31:0] r;
    bit found;
    d = 8'($urandom); found = 0;
    bus_write(32'h8, 32'd8); bus_write(32'h0, 32'hA);
    @(negedge clk); n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_idle got %b exp 0", irq_o); end
    fork
      send_rx(d, 1, 8);
      begin
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (data_o[2] === 1'b1) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL irq_rx_timeout: rx_valid not seen in 200 cycles"); end
        else begin
          n_cmp++;
          if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_lag got %b exp 0 with rx_valid", irq_o); end
          @(negedge clk); n_cmp++;
          if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b exp 1", irq_o); end
        end
        req_i = 1'b0;
      end
    join
    bus_read(32'hC, r); n_cmp++;
    if (r !== {24'h0, d}) begin n_err++; $display("FAIL irq_data got %h exp %h", r, d); end
    last_rx = d;
    @(negedge clk); n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_fall got %b exp 0", irq_o); end
    bus_write(32'h0, 32'h4);
    @(negedge clk); n_cmp++;
    if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_txe got %b exp 1", irq_o); end
    bus_write(32'h0, 32'h0);
    @(negedge clk); n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_txe_off got %b exp 0", irq_o); end
  endtask

  task automatic test_ctrl_bit4();
    logic [31:0] r, e;
`ifdef UART_LOOPBACK_EN
    e = 32'h1F;
`else
    e = 32'h0F;
`endif
    bus_write(32'h0, 32'h1F);
    bus_read(32'h0, r); n_cmp++;
    if (r !== e) begin n_err++; $display("FAIL ctrl_rw got %h exp %h", r, e); end
    bus_write(32'h0, 32'h0);
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [31:0] r;
    bit bad;
    bad = 0;
    bus_write(32'h8, 32'd4); bus_write(32'h0, 32'h13);
    bus_write(32'hC, 32'h5A);
    repeat (60) begin @(negedge clk); if (tx_o !== 1'b1) bad = 1; end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL loop_tx_held got low exp 1"); end
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h6) begin n_err++; $display("FAIL loop_status got %h exp 00000006", r); end
    bus_read(32'hC, r); n_cmp++;
    if (r !== 32'h5A) begin n_err++; $display("FAIL loop_data got %h exp 0000005a", r); end
    last_rx = 8'h5A;
    bus_write(32'h0, 32'h0);
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [31:0] r;
    bit bad;
    bad = 0;
    d = 8'($urandom) & 8'hFD;
    bus_write(32'h8, 32'd8);
    bus_write(32'hC, {24'h0, d});
    bus_write(32'hC, $urandom); bus_write(32'hC, $urandom);
    bus_write(32'h0, 32'h1);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b0) begin n_err++; $display("FAIL mid_pre got tx=%b exp 0 (data bit 1)", tx_o); end
    rst = 1'b1;
    @(negedge clk); n_cmp++;
    if (tx_o !== 1'b1) begin n_err++; $display("FAIL mid_tx_reset got %b exp 1", tx_o); end
    rst = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b0) begin n_err++; $display("FAIL mid_irq got %b exp 0", irq_o); end
    bus_read(32'h4, r); n_cmp++;
    if (r !== 32'h2) begin n_err++; $display("FAIL mid_status got %h exp 00000002", r); end
    bus_read(32'h0, r); n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL mid_ctrl got %h exp 00000000", r); end
    bus_read(32'h8, r); n_cmp++;
    if (r !== 32'd434) begin n_err++; $display("FAIL mid_baud got %0d exp 434", r); end
    bus_write(32'h0, 32'h1);
    repeat (30) begin @(negedge clk); if (tx_o !== 1'b1) bad = 1; end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL mid_fifo_empty: frame sent after reset"); end
    bus_write(32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_tx();
    test_baud_latch();
    test_fifo_full();
    test_rx();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_irq();
    test_ctrl_bit4();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
